// File: rtl/fp16_mul_pkg.sv
// rtl/fp16_mul_pkg.sv - shared constants, operand class and pipeline bundle for the fp16 multiply back end
package fp16_mul_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;
    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;

    typedef enum logic [2:0] {NORM, ZERO, INF, NAN, INV} fp_class_t;

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic signed [6:0] esum;
        fp_class_t         cls;
    } op_info_t;

    // A NaN operand dominates; inf times zero is the only invalid product.
    function automatic fp_class_t classify(input logic [EXP_W-1:0] a_exp,
                                           input logic [EXP_W-1:0] b_exp,
                                           input logic a_man_nz,
                                           input logic b_man_nz);
        logic any_nan;
        logic any_inf;
        logic any_zero;
        any_nan  = (&a_exp && a_man_nz) || (&b_exp && b_man_nz);
        any_inf  = (&a_exp && !a_man_nz) || (&b_exp && !b_man_nz);
        any_zero = (a_exp == '0) || (b_exp == '0);
        if (any_nan)
            return NAN;
        else if (any_inf)
            return any_zero ? INV : INF;
        else if (any_zero)
            return ZERO;
        else
            return NORM;
    endfunction

endpackage

// File: rtl/fp16_mul_post_if.sv
// rtl/fp16_mul_post_if.sv - operand/product inputs and packed result outputs of the fp16 multiply back end
interface fp16_mul_post_if;
    import fp16_mul_pkg::*;

    logic               in_valid;
    logic               a_sign;
    logic               b_sign;
    logic [EXP_W-1:0]   a_exp;
    logic [EXP_W-1:0]   b_exp;
    logic               a_man_nz;
    logic               b_man_nz;
    logic [23:0]        mul_prod;
    logic               out_valid;
    logic [15:0]        result;
    logic               flag_ovf;
    logic               flag_unf;
    logic               flag_inx;
    logic               flag_inv;

    modport master (
        output in_valid, a_sign, b_sign, a_exp, b_exp, a_man_nz, b_man_nz, mul_prod,
        input  out_valid, result, flag_ovf, flag_unf, flag_inx, flag_inv
    );

    modport slave (
        input  in_valid, a_sign, b_sign, a_exp, b_exp, a_man_nz, b_man_nz, mul_prod,
        output out_valid, result, flag_ovf, flag_unf, flag_inx, flag_inv
    );

endinterface

// File: rtl/fp16_mul_delay_line.sv
// rtl/fp16_mul_delay_line.sv - shift register keeping operand info aligned with the Booth multiplier latency
module fp16_mul_delay_line
    import fp16_mul_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic     CLK,
    input  logic     RST,
    input  op_info_t din,
    output op_info_t dout
);

    op_info_t stage [DEPTH];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++)
                stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fp16_mul_post.sv
// rtl/fp16_mul_post.sv - normalize, RNE round and pack of the fp16 product; FP16_MUL_STICKY_FLAGS_EN adds sticky flags
module fp16_mul_post
    import fp16_mul_pkg::*;
#(
    parameter int MUL_LAT = 8
) (
    input  logic            CLK,
    input  logic            RST,
    fp16_mul_post_if.slave  io
`ifdef FP16_MUL_STICKY_FLAGS_EN
    ,
    input  logic            flag_clr,
    output logic [3:0]      sticky_flags
`endif
);

    op_info_t issue_d;
    op_info_t issue_q;
    op_info_t aligned;

    always_comb begin
        issue_d       = '0;
        issue_d.valid = io.in_valid;
        issue_d.sign  = io.a_sign ^ io.b_sign;
        issue_d.esum  = $signed({2'b00, io.a_exp}) + $signed({2'b00, io.b_exp}) - 7'sd15;
        issue_d.cls   = classify(io.a_exp, io.b_exp, io.a_man_nz, io.b_man_nz);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            issue_q <= '0;
        else
            issue_q <= issue_d;
    end

    fp16_mul_delay_line #(.DEPTH(MUL_LAT - 1)) u_delay (
        .CLK  (CLK),
        .RST  (RST),
        .din  (issue_q),
        .dout (aligned)
    );

    // Product bits [23:22] are always zero for 11-bit significands.
    logic [21:0]       prod;
    logic              unused_prod_hi;
    logic signed [7:0] esum_ext;
    logic signed [7:0] e_norm;
    logic signed [7:0] e_fin;
    logic [MAN_W-1:0]  man;
    logic [MAN_W:0]    man_rnd;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic              inexact;
    logic [15:0]       res_d;
    logic [3:0]        flg_d;

    assign prod           = io.mul_prod[21:0];
    assign unused_prod_hi = |io.mul_prod[23:22];
    assign esum_ext       = {aligned.esum[6], aligned.esum};

    always_comb begin
        man    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        e_norm = esum_ext;
        if (prod[21]) begin
            man    = prod[20:11];
            guard  = prod[10];
            sticky = |prod[9:0];
            e_norm = esum_ext + 8'sd1;
        end else begin
            man    = prod[19:10];
            guard  = prod[9];
            sticky = |prod[8:0];
        end
        round_up = guard & (sticky | man[0]);
        man_rnd  = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
        e_fin    = man_rnd[MAN_W] ? e_norm + 8'sd1 : e_norm;
        inexact  = guard | sticky;
    end

    // flg_d is {inv, ovf, unf, inx}
    always_comb begin
        res_d = '0;
        flg_d = '0;
        case (aligned.cls)
            NAN:  res_d = QNAN;
            INV: begin
                res_d    = QNAN;
                flg_d[3] = 1'b1;
            end
            INF:  res_d = {aligned.sign, PINF[14:0]};
            ZERO: res_d = {aligned.sign, 15'b0};
            default: begin
                if (e_fin >= 8'sd31) begin
                    res_d = {aligned.sign, PINF[14:0]};
                    flg_d = 4'b0101;
                end else if (e_fin <= 8'sd0) begin
                    res_d = {aligned.sign, 15'b0};
                    flg_d = 4'b0011;
                end else begin
                    res_d    = {aligned.sign, e_fin[4:0], man_rnd[MAN_W-1:0]};
                    flg_d[0] = inexact;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            io.out_valid <= 1'b0;
            io.result    <= '0;
            io.flag_inv  <= 1'b0;
            io.flag_ovf  <= 1'b0;
            io.flag_unf  <= 1'b0;
            io.flag_inx  <= 1'b0;
        end else begin
            io.out_valid <= aligned.valid;
            io.result    <= aligned.valid ? res_d : '0;
            io.flag_inv  <= aligned.valid & flg_d[3];
            io.flag_ovf  <= aligned.valid & flg_d[2];
            io.flag_unf  <= aligned.valid & flg_d[1];
            io.flag_inx  <= aligned.valid & flg_d[0];
        end
    end

`ifdef FP16_MUL_STICKY_FLAGS_EN
    logic [3:0] new_flags;
    assign new_flags = io.out_valid ? {io.flag_inv, io.flag_ovf, io.flag_unf, io.flag_inx} : 4'b0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            sticky_flags <= '0;
        else if (flag_clr)
            sticky_flags <= new_flags;
        else
            sticky_flags <= sticky_flags | new_flags;
    end
`endif

endmodule
